instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 12 +
 rtl/ifetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: reset defaults and the fetch FSM state type.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer holding fetched words together with their PCs.
// Head outputs read as zero while empty so nothing stale reaches the decoder.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [31:0]            push_instr,
  input  logic [31:0]            push_pc,
  input  logic                   pop,
  output logic [31:0]            head_instr,
  output logic [31:0]            head_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH[PtrW:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr_q] <= push_instr;
      pc_mem[wr_ptr_q]    <= push_pc;
    end
  end

  assign head_instr = empty ? '0 : instr_mem[rd_ptr_q];
  assign head_pc    = empty ? '0 : pc_mem[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited requests, in-order response buffering,
// redirect flush. Define IFETCH_ALIGN_CHK_EN to trap misaligned redirect targets.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  ifetch_state_e   state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] fifo_count, outst_ret;
  logic [CntW:0]   inflight;
  logic [31:0]     redir_target;
  logic            fifo_full, fifo_empty;
  logic            gnt_acc, push, pop;

`ifdef IFETCH_ALIGN_CHK_EN
  logic err_q;

  assign redir_target = redirect_pc;
  assign fetch_err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | (redirect_valid & |redirect_pc[1:0]);
  end
`else
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_err    = 1'b0;
`endif

  assign gnt_acc     = imem_req && imem_gnt;
  assign pop         = instr_valid && instr_ready;
  assign push        = imem_rvalid && (state_q == StRun) && !redirect_valid;
  assign instr_valid = !fifo_empty;
  assign inflight    = {1'b0, fifo_count} + {1'b0, outst_q};
  // A response retiring this cycle frees an outstanding slot immediately.
  assign outst_ret   = outst_q - {{(CntW-1){1'b0}}, imem_rvalid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StRun;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (outst_d != '0) ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StRun:   state_d = StRun;
        StFlush: if (drop_d == '0) state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // rst gates the request so nothing is issued while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    if (rst && (state_q == StRun) && !fetch_err && !fifo_full) begin
      imem_req = (inflight < FIFO_DEPTH[CntW:0]) && (outst_ret < MAX_OUTST[CntW-1:0]);
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + {{(CntW-1){1'b0}}, gnt_acc} - {{(CntW-1){1'b0}}, imem_rvalid};
    if (redirect_valid) begin
      fetch_pc_d = redir_target;
      rsp_pc_d   = redir_target;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = outst_d;
    end else begin
      if (gnt_acc) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)    rsp_pc_d   = rsp_pc_q + 32'd4;
      if ((state_q == StFlush) && imem_rvalid) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (redirect_valid),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (rsp_pc_q),
    .pop        (pop),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule
